// File: rtl/mdio_pkg.sv
// Shared MDIO frame definitions: field positions, opcodes, slot landmarks and FSM states.
package mdio_pkg;

  localparam int unsigned FRAME_BITS = 32;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Frame field bit positions
  localparam int unsigned ST_MSB   = 31;
  localparam int unsigned ST_LSB   = 30;
  localparam int unsigned OP_MSB   = 29;
  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned PHY_MSB  = 27;
  localparam int unsigned PHY_LSB  = 23;
  localparam int unsigned REG_MSB  = 22;
  localparam int unsigned REG_LSB  = 18;
  localparam int unsigned TA_MSB   = 17;
  localparam int unsigned TA_LSB   = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  // Slot landmarks within the 32-slot frame
  localparam logic [5:0] READ_RELEASE_SLOT  = 6'd14;
  localparam logic [5:0] CAPTURE_FIRST_SLOT = 6'd16;
  localparam logic [5:0] LAST_SLOT          = 6'd31;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPreamble = 2'd1,
    StShift    = 2'd2,
    StDone     = 2'd3
  } mdio_state_e;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdc_clkgen.sv
// MDC divider: each bit slot is CLK_DIV cycles low then CLK_DIV cycles high.
// slot_start_o and sample_strobe_o both flag the final cycle of a slot: the closing
// edge starts the next slot and is also the last MDC-high cycle, where MDIO is sampled.
module mdc_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic mdc_o,
  output logic slot_start_o,
  output logic sample_strobe_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            phase_q, phase_d;
  logic            half_end;

  assign half_end = (div_cnt_q == DivW'(CLK_DIV - 1));

  // Next-state: count through each half period, cleared while not running
  always_comb begin
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    if (!run_i) begin
      div_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (half_end) begin
      div_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end
  end

  // Divider state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign mdc_o           = phase_q;
  assign slot_start_o    = run_i & phase_q & half_end;
  assign sample_strobe_o = run_i & phase_q & half_end;

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-side master: optional preamble, 32-bit frame MSB first, read capture.
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PRE_LEN = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic        MDIO_DONE,
  output logic        DATA_RDY,
  output logic [15:0] RD_DATA,
  output logic        BUSY
);

  mdio_state_e state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        run, slot_end, sample_strobe;
  logic        is_read;

  assign run     = (state_q == StPreamble) || (state_q == StShift);
  assign is_read = (frame_q[OP_MSB:OP_LSB] == OP_READ);

  mdc_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i          (CLK),
    .reset_i        (RESET),
    .run_i          (run),
    .mdc_o          (MDC),
    .slot_start_o   (slot_end),
    .sample_strobe_o(sample_strobe)
  );

  // FSM next-state: accept, preamble count, frame shift and read capture
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (MDIO_START && op_is_valid(T_DATA[OP_MSB:OP_LSB])) begin
          frame_d = T_DATA;
          state_d = (PRE_LEN > 0) ? StPreamble : StShift;
        end
      end
      StPreamble: begin
        if (slot_end) begin
          if (bit_cnt_q == 6'(PRE_LEN - 1)) begin
            bit_cnt_d = '0;
            state_d   = StShift;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StShift: begin
        if (sample_strobe && is_read && (bit_cnt_q >= CAPTURE_FIRST_SLOT)) begin
          rx_d = {rx_q[14:0], MDIO_IN};
        end
        if (slot_end) begin
          if (bit_cnt_q == LAST_SLOT) begin
            // Counter holds at the last slot; it is cleared again in idle
            state_d = StDone;
            if (is_read) begin
              rd_data_d = rx_d;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin decode for the slot about to start, so MDIO changes only at slot boundaries
  always_comb begin
    oe_d  = 1'b0;
    out_d = 1'b0;
    case (state_d)
      StPreamble: begin
        oe_d  = 1'b1;
        out_d = 1'b1;
      end
      StShift: begin
        // Read frames hand the bus to the PHY from the turnaround onwards
        if (!((frame_d[OP_MSB:OP_LSB] == OP_READ) && (bit_cnt_d >= READ_RELEASE_SLOT))) begin
          oe_d  = 1'b1;
          out_d = frame_d[5'd31 - bit_cnt_d[4:0]];
        end
      end
      default: begin
        oe_d  = 1'b0;
        out_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  assign MDIO_OE   = oe_q;
  assign MDIO_OUT  = out_q;
  assign MDIO_DONE = (state_q == StDone);
  assign DATA_RDY  = (state_q == StDone) && is_read;
  assign RD_DATA   = rd_data_q;
  assign BUSY      = (state_q != StIdle);

endmodule
